mpc_mem_responder: RTL and testbench

- External-memory responder for the multi-port cache: the responder end of the cache's MEM_OP_LOAD / MEM_OP_STORE request interface.
- Holds a line-granular 128-bit backing store, services requests strictly in order, and returns each response after a programmable fixed latency.
- Applies backpressure through a bounded outstanding-request queue.
- Used as the memory side in subsystem simulation and as the on-chip scratch memory target.

---
 rtl/mpc_mem_responder.sv | 139 +++++++++++++
 tb/tb_mpc_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_mem_responder.sv
// mpc_mem_responder: in-order fixed-latency line memory responder.
// Optional address range check: define MPC_MEM_RSP_ADDR_CHECK_EN.
module mpc_mem_responder #(
  parameter int unsigned LINES  = 256,
  parameter int unsigned LAT    = 4,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned ID_W   = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [31:0]     req_addr_i,
  input  logic [127:0]    req_wdata_i,
  input  logic [ID_W-1:0] req_id_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [2:0]      rsp_op_o,
  output logic [127:0]    rsp_rdata_o,
  output logic [ID_W-1:0] rsp_id_o,
  output logic            rsp_err_o
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(LAT) + 1;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;

  logic [127:0]    mem_q [LINES];

  logic [2:0]      q_op_q    [QDEPTH];
  logic [ID_W-1:0] q_id_q    [QDEPTH];
  logic [127:0]    q_rdata_q [QDEPTH];
  logic            q_err_q   [QDEPTH];
  logic [TW-1:0]   q_tmr_q   [QDEPTH];
  logic            q_vld_q   [QDEPTH];

  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]   idx;
  logic            is_ld, is_st;
  logic            bad_op, bad_addr, err;
  logic            acc, ret, head_rdy;
  logic [127:0]    rd;
  logic            unused_addr;

  assign idx    = req_addr_i[4+IW-1:4];
  assign is_ld  = (req_op_i == OP_LOAD);
  assign is_st  = (req_op_i == OP_STORE);
  assign bad_op = !(is_ld || is_st);

`ifdef MPC_MEM_RSP_ADDR_CHECK_EN
  assign bad_addr    = |req_addr_i[31:4+IW];
  assign unused_addr = ^req_addr_i[3:0];
`else
  assign bad_addr    = 1'b0;
  assign unused_addr = ^{req_addr_i[31:4+IW], req_addr_i[3:0]};
`endif

  assign err = bad_op || bad_addr;

  // Backpressure depends only on the registered occupancy.
  assign req_ready_o = (cnt_q < CW'(QDEPTH));
  assign acc         = req_valid_i && req_ready_o;

  assign head_rdy = q_vld_q[rptr_q] && (q_tmr_q[rptr_q] == '0);
  assign ret      = head_rdy && rsp_ready_i;

  // Read happens at accept so ordering follows acceptance order.
  assign rd = (is_ld && !err) ? mem_q[idx] : '0;

  // Response fields are zero whenever nothing is being offered.
  assign rsp_valid_o = head_rdy;
  assign rsp_op_o    = head_rdy ? q_op_q[rptr_q]    : '0;
  assign rsp_rdata_o = head_rdy ? q_rdata_q[rptr_q] : '0;
  assign rsp_id_o    = head_rdy ? q_id_q[rptr_q]    : '0;
  assign rsp_err_o   = head_rdy ? q_err_q[rptr_q]   : 1'b0;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (acc) wptr_d = wptr_q + PW'(1);
    if (ret) rptr_d = rptr_q + PW'(1);
    unique case ({acc, ret})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Backing store write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (acc && is_st && !err) mem_q[idx] <= req_wdata_i;
  end

  // Queue state: pointers, count and per-entry fields/timers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_op_q[i]    <= '0;
        q_id_q[i]    <= '0;
        q_rdata_q[i] <= '0;
        q_err_q[i]   <= 1'b0;
        q_tmr_q[i]   <= '0;
        q_vld_q[i]   <= 1'b0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_vld_q[i] && q_tmr_q[i] != '0)
          q_tmr_q[i] <= q_tmr_q[i] - TW'(1);
        if (ret && PW'(i) == rptr_q)
          q_vld_q[i] <= 1'b0;
        if (acc && PW'(i) == wptr_q) begin
          q_op_q[i]    <= req_op_i;
          q_id_q[i]    <= req_id_i;
          q_rdata_q[i] <= rd;
          q_err_q[i]   <= err;
          q_tmr_q[i]   <= TW'(LAT - 1);
          q_vld_q[i]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpc_mem_responder.sv
// tb_mpc_mem_responder: directed checks for mpc_mem_responder.
// Inputs driven and outputs sampled on the falling edge.
module tb_mpc_mem_responder;

  localparam int unsigned LAT  = 4;
  localparam int unsigned ID_W = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [31:0]     req_addr;
  logic [127:0]    req_wdata;
  logic [ID_W-1:0] req_id;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2:0]      rsp_op;
  logic [127:0]    rsp_rdata;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_err;

  int checks = 0;
  int fails  = 0;

  localparam logic [127:0] W0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] W1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] W2 = 128'hA5A5_A5A5_5A5A_5A5A_1234_5678_9ABC_DEF0;
  localparam logic [127:0] W3 = 128'hFFFF_0000_FFFF_0000_CAFE_F00D_BEEF_0001;
  localparam logic [127:0] W4 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  mpc_mem_responder #(
    .LINES(256), .LAT(LAT), .QDEPTH(4), .ID_W(ID_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_op_o(rsp_op), .rsp_rdata_o(rsp_rdata),
    .rsp_id_o(rsp_id), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request, then wait (bounded) for its response and retire it.
  task automatic xact(input  logic [2:0]      op,
                      input  logic [31:0]     a,
                      input  logic [127:0]    wd,
                      input  logic [ID_W-1:0] id,
                      output logic [127:0]    rd,
                      output logic            er,
                      output logic [ID_W-1:0] rid,
                      output int              lat);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    req_id    = id;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd  = rsp_rdata;
    er  = rsp_err;
    rid = rsp_id;
    @(negedge clk);
  endtask

  logic [127:0]    rd;
  logic            er;
  logic [ID_W-1:0] rid;
  int              lat;
  int              nv;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_id    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_ready", 128'(req_ready), 128'(1));
    chk("rst_valid", 128'(rsp_valid), 128'(0));
    chk("rst_err",   128'(rsp_err),   128'(0));
    chk("rst_rdata", rsp_rdata,       128'(0));
    chk("rst_id",    128'(rsp_id),    128'(0));
    chk("rst_op",    128'(rsp_op),    128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load, back to back.
    req_valid = 1'b1;
    req_op    = 3'd1;
    req_addr  = 32'h0000_0010;
    req_wdata = W0;
    req_id    = 3'd1;
    @(negedge clk);
    req_op    = 3'd0;
    req_id    = 3'd2;
    req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT - 3) @(negedge clk);
    chk("st_early", 128'(rsp_valid), 128'(0));
    @(negedge clk);
    chk("st_valid", 128'(rsp_valid), 128'(1));
    chk("st_id",    128'(rsp_id),    128'(1));
    chk("st_op",    128'(rsp_op),    128'(1));
    chk("st_rdata", rsp_rdata,       128'(0));
    chk("st_err",   128'(rsp_err),   128'(0));
    @(negedge clk);
    chk("ld_valid", 128'(rsp_valid), 128'(1));
    chk("ld_id",    128'(rsp_id),    128'(2));
    chk("ld_op",    128'(rsp_op),    128'(0));
    chk("ld_rdata", rsp_rdata,       W0);
    @(negedge clk);
    chk("ld_done",  128'(rsp_valid), 128'(0));

    // Backpressure fill and stall stability.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_addr  = 32'h0000_0010;
    for (int k = 0; k < 4; k++) begin
      req_id = ID_W'(k);
      @(negedge clk);
    end
    req_id = 3'd4;
    chk("bp_full", 128'(req_ready), 128'(0));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", 128'(rsp_valid), 128'(1));
      chk("stall_id",    128'(rsp_id),    128'(0));
      chk("stall_rdata", rsp_rdata,       W0);
      chk("stall_ready", 128'(req_ready), 128'(0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_reready", 128'(req_ready), 128'(1));
    chk("bp_id1",     128'(rsp_id),    128'(1));
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_id2", 128'(rsp_id), 128'(2));
    @(negedge clk);
    chk("bp_id3", 128'(rsp_id), 128'(3));
    @(negedge clk);
    chk("bp_gap", 128'(rsp_valid), 128'(0));
    @(negedge clk);
    chk("bp_v4",  128'(rsp_valid), 128'(1));
    chk("bp_id4", 128'(rsp_id),    128'(4));
    chk("bp_rd4", rsp_rdata,       W0);
    @(negedge clk);
    chk("bp_done", 128'(rsp_valid), 128'(0));

    // Illegal op leaves memory untouched.
    xact(3'd5, 32'h0000_0010, W1, 3'd6, rd, er, rid, lat);
    chk("ill_lat",   128'(lat), 128'(LAT - 1));
    chk("ill_err",   128'(er),  128'(1));
    chk("ill_rdata", rd,        128'(0));
    chk("ill_id",    128'(rid), 128'(6));
    xact(3'd0, 32'h0000_0010, '0, 3'd7, rd, er, rid, lat);
    chk("ill_mem", rd,         W0);
    chk("ill_lderr", 128'(er), 128'(0));

    // Reset with requests in flight.
    xact(3'd1, 32'h0000_0020, W2, 3'd3, rd, er, rid, lat);
    chk("pre_rst_err", 128'(er), 128'(0));
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = 3'd0;
    for (int k = 0; k < 3; k++) begin
      req_id = ID_W'(k);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("inflt_valid", 128'(rsp_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_async", 128'(rsp_valid), 128'(0));
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    chk("rst_norsp", 128'(nv), 128'(0));
    xact(3'd0, 32'h0000_0020, '0, 3'd5, rd, er, rid, lat);
    chk("rst_keep",  rd,         W2);
    chk("rst_ldid",  128'(rid),  128'(5));

    // Upper address bits: alias or address error.
    xact(3'd1, 32'h0000_0000, W3, 3'd1, rd, er, rid, lat);
    xact(3'd1, 32'h0000_1000, W4, 3'd2, rd, er, rid, lat);
`ifdef MPC_MEM_RSP_ADDR_CHECK_EN
    chk("ac_err",   128'(er), 128'(1));
    chk("ac_rdata", rd,       128'(0));
    xact(3'd0, 32'h0000_0000, '0, 3'd3, rd, er, rid, lat);
    chk("ac_line0", rd, W3);
`else
    chk("alias_err", 128'(er), 128'(0));
    xact(3'd0, 32'h0000_0000, '0, 3'd3, rd, er, rid, lat);
    chk("alias_line0", rd, W4);
`endif
    chk("last_lat", 128'(lat), 128'(LAT - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
